systolic_result_streamer: RTL and testbench

- Reader at the output end of the Systolic_Array result interface.
- Captures the flat `result` bus when the array raises `done`, then drains the product matrix one element per handshake over a valid/ready stream.
- Elements go out in row-major order, tagged with row/column indices and a last flag.
- Feeds downstream logic, such as a UART or FIFO, that cannot take the 144-bit bus in parallel.

---
 rtl/systolic_result_streamer_pkg.sv | 19 +
 rtl/systolic_result_streamer_if.sv | 22 ++
 rtl/systolic_result_streamer.sv | 121 ++++++++++++
 tb/tb_systolic_result_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_streamer_pkg.sv
// Shared definitions for the systolic array and its result reader: matrix
// geometry, the reader FSM state type and the flat-bus element slice helper.
package systolic_pkg;
    localparam int MAT_ROWS  = 3;
    localparam int MAT_COLS  = 3;
    localparam int MAT_LEN   = MAT_ROWS * MAT_COLS;
    localparam int DATA_SIZE = 8;
    localparam int ACC_SIZE  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;

    // MSB bit position of element k on the flat bus; k=0 sits in the top slice.
    function automatic int elem_msb(input int k, input int len, input int width);
        return (len - k) * width - 1;
    endfunction
endpackage

// File: rtl/systolic_result_streamer_if.sv
// Valid/ready element stream carrying one result element plus its row/column
// tags and an end-of-matrix flag.
interface systolic_result_streamer_if #(
    parameter int ACC_SIZE = systolic_pkg::ACC_SIZE
);
    logic [ACC_SIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [1:0]          out_row;
    logic [1:0]          out_col;

    modport master (
        output out_data, out_valid, out_last, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_streamer.sv
// Snapshots the array result bus on the rising edge of done and drains it
// row-major, one element per valid/ready handshake.
module systolic_result_streamer #(
    parameter int MAT_ROWS = systolic_pkg::MAT_ROWS,
    parameter int MAT_COLS = systolic_pkg::MAT_COLS,
    parameter int MAT_LEN  = systolic_pkg::MAT_LEN,
    parameter int ACC_SIZE = systolic_pkg::ACC_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         done_in,
    input  logic [MAT_LEN*ACC_SIZE-1:0]  result_in,
    systolic_result_streamer_if.master   strm,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         clear_overrun
);
    import systolic_pkg::*;

    localparam int K_W = $clog2(MAT_LEN);

    stream_state_t               state_q, state_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [1:0]                  row_q, row_d;
    logic [1:0]                  col_q, col_d;
    logic                        done_q;
    logic [MAT_LEN*ACC_SIZE-1:0] shadow_q, shadow_d;
    logic                        overrun_q, overrun_d;

    logic cap;
    logic hs;
    logic at_last;
    int   sel_msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_in;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;

        cap     = done_in & ~done_q;
        hs      = (state_q == SEND) & strm.out_ready;
        at_last = (state_q == SEND) && (row_q == 2'(MAT_ROWS - 1)) && (col_q == 2'(MAT_COLS - 1));

        if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cap) begin
                    shadow_d = result_in;
                    k_d      = '0;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (hs && at_last) begin
                    // A capture coinciding with the final handshake starts the next matrix with no bubble.
                    k_d   = '0;
                    row_d = '0;
                    col_d = '0;
                    if (cap) begin
                        shadow_d = result_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        k_d = k_q + 1'b1;
                        if (col_q == 2'(MAT_COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                    if (cap) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_msb        = elem_msb(int'(k_q), MAT_LEN, ACC_SIZE);
        busy           = (state_q == SEND);
        overrun        = overrun_q;
        strm.out_valid = busy;
        strm.out_last  = at_last;
        strm.out_row   = row_q;
        strm.out_col   = col_q;
        strm.out_data  = busy ? shadow_q[sel_msb -: ACC_SIZE] : '0;
    end
endmodule

// File: tb/tb_systolic_result_streamer.sv
// Directed bench for systolic_result_streamer: drain, backpressure, level done,
// overrun, back-to-back capture and mid-stream reset.
module tb_systolic_result_streamer;
    typedef int exp_t [9];

    logic         clk;
    logic         reset;
    logic         done_in;
    logic [143:0] result_in;
    logic         busy;
    logic         overrun;
    logic         clear_overrun;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [143:0] VEC1 = 144'h016D_00EA_0272_0015_0066_0048_0164_0250_02E5;
    localparam logic [143:0] VEC2 = 144'h016D_0086_0272_0015_0066_0048_0164_0250_02E5;

    exp_t exp1 = '{365, 234, 626, 21, 102, 72, 356, 592, 741};
    exp_t exp2 = '{365, 134, 626, 21, 102, 72, 356, 592, 741};

    systolic_result_streamer_if sif ();

    systolic_result_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .done_in       (done_in),
        .result_in     (result_in),
        .strm          (sif),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drains one matrix starting at the current negedge. pat_mode 0: always
    // ready; 1: ready pattern 1,0,0,1,0,1. fire_k >= 0 raises done_in with vec2
    // on the handshake of element fire_k and keeps done_in low otherwise.
    task automatic drain(input string tag, input exp_t exp, input int pat_mode,
                         input int fire_k, input logic [143:0] vec2);
        int  k = 0;
        int  cyc = 0;
        bit  held = 0;
        bit  fired = 0;
        bit  rdy;
        logic [15:0] held_data;
        logic [1:0]  held_row, held_col;
        while (k < 9 && cyc < 200) begin
            case (cyc % 6)
                0, 3, 5: rdy = 1'b1;
                default: rdy = 1'b0;
            endcase
            if (pat_mode == 0) rdy = 1'b1;
            sif.out_ready = rdy;
            if (held) begin
                check_eq({tag, "_hold_data"}, 32'(sif.out_data), 32'(held_data));
                check_eq({tag, "_hold_row"}, 32'(sif.out_row), 32'(held_row));
                check_eq({tag, "_hold_col"}, 32'(sif.out_col), 32'(held_col));
                held = 0;
            end
            if (fire_k >= 0) begin
                if (sif.out_valid && rdy && k == fire_k && !fired) begin
                    done_in   = 1'b1;
                    result_in = vec2;
                    fired     = 1;
                end else if (k != fire_k || fired) begin
                    done_in = (k == fire_k + 1 && fire_k == 8) ? done_in : 1'b0;
                end
            end
            if (sif.out_valid && rdy) begin
                check_eq($sformatf("%s_data%0d", tag, k), 32'(sif.out_data), 32'(exp[k]));
                check_eq($sformatf("%s_row%0d", tag, k), 32'(sif.out_row), 32'(k / 3));
                check_eq($sformatf("%s_col%0d", tag, k), 32'(sif.out_col), 32'(k % 3));
                check_eq($sformatf("%s_last%0d", tag, k), 32'(sif.out_last), 32'(k == 8));
                k++;
            end else if (sif.out_valid) begin
                held      = 1;
                held_data = sif.out_data;
                held_row  = sif.out_row;
                held_col  = sif.out_col;
            end else begin
                check_eq({tag, "_valid_drop"}, 32'(sif.out_valid), 32'd1);
            end
            step();
            cyc++;
        end
        check_eq({tag, "_handshakes"}, 32'(k), 32'd9);
        sif.out_ready = 1'b1;
    endtask

    initial begin
        int vcount;
        reset         = 1'b1;
        done_in       = 1'b0;
        result_in     = '0;
        clear_overrun = 1'b0;
        sif.out_ready = 1'b0;
        step();
        check_eq("rst_valid", 32'(sif.out_valid), 32'd0);
        check_eq("rst_data", 32'(sif.out_data), 32'd0);
        check_eq("rst_last", 32'(sif.out_last), 32'd0);
        check_eq("rst_rowcol", {28'd0, sif.out_row, sif.out_col}, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Basic drain
        result_in     = VEC1;
        done_in       = 1'b1;
        sif.out_ready = 1'b1;
        step();
        done_in = 1'b0;
        check_eq("basic_lat_valid", 32'(sif.out_valid), 32'd1);
        check_eq("basic_busy", 32'(busy), 32'd1);
        drain("basic", exp1, 0, -1, VEC1);
        check_eq("basic_end_valid", 32'(sif.out_valid), 32'd0);
        check_eq("basic_end_busy", 32'(busy), 32'd0);
        step();

        // Backpressure
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        drain("bp", exp1, 1, -1, VEC1);
        check_eq("bp_end_valid", 32'(sif.out_valid), 32'd0);
        step();

        // Level done held for 20 cycles
        done_in = 1'b1;
        step();
        drain("lvl", exp1, 0, -1, VEC1);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (sif.out_valid) vcount++;
            step();
        end
        done_in = 1'b0;
        check_eq("lvl_extra_valid", 32'(vcount), 32'd0);
        check_eq("lvl_overrun", 32'(overrun), 32'd0);
        step();

        // Overrun: second edge at element 4
        result_in = VEC1;
        done_in   = 1'b1;
        step();
        done_in = 1'b0;
        drain("ovr", exp1, 0, 4, VEC2);
        done_in = 1'b0;
        check_eq("ovr_end_valid", 32'(sif.out_valid), 32'd0);
        check_eq("ovr_set", 32'(overrun), 32'd1);
        step();
        step();
        check_eq("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'd0);
        step();

        // Back-to-back: capture on the handshake of the last element
        result_in = VEC1;
        done_in   = 1'b1;
        step();
        done_in = 1'b0;
        drain("b2b_a", exp1, 0, 8, VEC2);
        done_in = 1'b0;
        check_eq("b2b_valid", 32'(sif.out_valid), 32'd1);
        check_eq("b2b_data0", 32'(sif.out_data), 32'd365);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_overrun", 32'(overrun), 32'd0);
        drain("b2b_b", exp2, 0, -1, VEC2);
        check_eq("b2b_end_valid", 32'(sif.out_valid), 32'd0);
        step();

        // Reset mid-stream with overrun set
        result_in = VEC1;
        done_in   = 1'b1;
        step();
        done_in = 1'b0;
        step();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check_eq("mrst_pre_data", 32'(sif.out_data), 32'd626);
        check_eq("mrst_pre_overrun", 32'(overrun), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_valid", 32'(sif.out_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_overrun", 32'(overrun), 32'd0);
        check_eq("mrst_data", 32'(sif.out_data), 32'd0);
        step();
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sif.out_valid) vcount++;
        end
        check_eq("mrst_quiet", 32'(vcount), 32'd0);
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check_eq("mrst_restart_valid", 32'(sif.out_valid), 32'd1);
        drain("mrst", exp1, 0, -1, VEC1);
        check_eq("mrst_end_valid", 32'(sif.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
